// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // ALU operand / store-data source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Controller sequencing state
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects plus the ID-vs-EX register matches used for load-use detection.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow the pipeline register fields directly.
// Ports: ex_rs/ex_rt/mem_*/wb_* in -> fwd_a_sel, fwd_b_sel, fwd_store_data;
//        id_rs/id_rt/ex_rd in -> rs_ld_match, rt_ld_match.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] mem_rt,
  input  logic              mem_regwrt,
  input  logic              mem_memread,
  input  logic              mem_is_store,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrt,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              fwd_store_data,
  output logic              rs_ld_match,
  output logic              rt_ld_match
);

  // Register 0 is never a real producer when it is hardwired to zero.
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // A load in EX/MEM has no data yet, so only non-load writers forward from there.
  function automatic logic [1:0] sel_src(input logic [REG_AW-1:0] src);
    if (mem_regwrt && !mem_memread && reg_match(src, mem_rd)) return FWD_EXMEM;
    else if (wb_regwrt && reg_match(src, wb_rd))              return FWD_MEMWB;
    else                                                      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_sel      = sel_src(ex_rs);
    fwd_b_sel      = sel_src(ex_rt);
    fwd_store_data = mem_is_store && wb_regwrt && reg_match(mem_rt, wb_rd);
    rs_ld_match    = reg_match(id_rs, ex_rd);
    rt_ld_match    = reg_match(id_rt, ex_rd);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding, load-use stall, memory wait/timeout, branch flush, halt drain, stall counter.
// Latency: control outputs are combinational from inputs and state; hlt/perf counter are registered.
// Backpressure: memory wait freezes PC..EX/MEM and bubbles MEM/WB; load-use freezes PC/IF-ID for one cycle.
// Ports: ID/EX/MEM/WB register fields and control bits in; fwd selects, stage enables/flushes,
//        hlt, mem_timeout and perf_stall_cnt out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int ZERO_REG  = 1,
  parameter int MAX_WAIT  = 255,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              id_hlt,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] mem_rt,
  input  logic              mem_regwrt,
  input  logic              mem_memread,
  input  logic              mem_is_store,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrt,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              fwd_store_data,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              mem_wb_bubble,
  output logic              hlt,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  localparam int              DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC - 1);
  localparam logic [15:0]     WAIT_MAX   = 16'(MAX_WAIT);
  localparam logic [15:0]     WAIT_LAST  = 16'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs_ld_match, rt_ld_match;
  logic memwait, loaduse;

  fwd_unit #(
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_fwd (
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .mem_rd         (mem_rd),
    .mem_rt         (mem_rt),
    .mem_regwrt     (mem_regwrt),
    .mem_memread    (mem_memread),
    .mem_is_store   (mem_is_store),
    .wb_rd          (wb_rd),
    .wb_regwrt      (wb_regwrt),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .fwd_store_data (fwd_store_data),
    .rs_ld_match    (rs_ld_match),
    .rt_ld_match    (rt_ld_match)
  );

  assign memwait = mem_req && !mem_ready;
  // Store data is forwarded at MEM, so a store's rt never needs the stall.
  assign loaduse = ex_memread &&
                   ((id_rs_used && rs_ld_match) || (id_rt_used && !id_is_store && rt_ld_match));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;

    // Stage control by priority: halted > memwait > loaduse > drain > branch.
    if (state_q == ST_HALTED) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (memwait) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (loaduse) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      // A branch seen during a stall is dropped; ID presents it again.
      if_id_flush = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (id_hlt && !memwait && !loaduse) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Older stages only advance when memory is not holding them.
        if (!memwait) begin
          if (drain_cnt_q == DRAIN_LAST) state_d     = ST_HALTED;
          else                           drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (memwait) wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 16'd1;
    // Raised during the MAX_WAIT-th consecutive wait cycle, then held.
    mem_timeout = timeout_q || (memwait && (wait_cnt_q == WAIT_LAST));
    timeout_d   = mem_timeout;

    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_HALTED) && !pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hlt            = (state_q == ST_HALTED);
  assign perf_stall_cnt = stall_cnt_q;

endmodule
